fphub_mult_pipe: RTL and testbench

Pipelined, parametrised HUB-format floating-point multiplier with valid/ready streaming handshake, configurable pipeline depth, sideband tag passthrough, explicit NaN handling, exponent overflow/underflow saturation and status flags. It replaces the single-register start-strobed HUB multiplier in the arithmetic datapath. It accepts one operand pair per cycle and stalls the whole pipeline on output backpressure.

---
 rtl/fphub_mult_pipe.sv | 171 +++++++++++++++++
 tb/tb_fphub_mult_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fphub_mult_pipe.sv
// HUB-format floating-point multiplier with a configurable-depth pipeline,
// valid/ready handshake, tag passthrough and status flags
// {invalid, overflow, underflow, special}.
module fphub_mult_pipe #(
  parameter int unsigned M      = 23,
  parameter int unsigned E      = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     Z,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);

  localparam int unsigned W   = 1 + E + M;
  localparam int unsigned MW  = M + 2;
  localparam int unsigned PW  = 2 * MW;
  localparam int unsigned ESW = E + 2;

  localparam logic        [ESW-1:0] BIAS    = ESW'(2 ** (E - 1));
  localparam logic signed [ESW-1:0] ES_MAX  = ESW'((2 ** E) - 1);
  localparam logic signed [ESW-1:0] ES_ZERO = '0;
  localparam logic signed [ESW-1:0] ES_ONE  = ESW'(1);

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

  typedef struct packed {
    cls_e             cls;
    logic             sign;
    logic [PW-1:0]    p;
    logic [ESW-1:0]   es;
    logic [TAG_W-1:0] tag;
  } mid_t;

  logic stall;
  mid_t front;
  mid_t back;
  logic back_valid;

  logic x_zero, x_inf, x_nan;
  logic y_zero, y_inf, y_nan;

  logic signed [ESW-1:0] es_n;
  logic [M-1:0]          mant_n;
  logic [W-1:0]          z_d;
  logic [3:0]            flags_d;
  logic                  p_unused;

  // The whole pipe freezes only when a result is waiting and not taken
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Classify operands, form raw HUB product and pre-normalisation exponent
  always_comb begin
    x_zero = (X[W-2:M] == '0);
    x_inf  = (X[W-2:M] == '1) && (X[M-1:0] == '0);
    x_nan  = (X[W-2:M] == '1) && (X[M-1:0] != '0);
    y_zero = (Y[W-2:M] == '0);
    y_inf  = (Y[W-2:M] == '1) && (Y[M-1:0] == '0);
    y_nan  = (Y[W-2:M] == '1) && (Y[M-1:0] != '0);

    front = '0;
    if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero))
      front.cls = CLS_NAN;
    else if (x_inf || y_inf)
      front.cls = CLS_INF;
    else if (x_zero || y_zero)
      front.cls = CLS_ZERO;
    else
      front.cls = CLS_NORM;

    front.sign = X[W-1] ^ Y[W-1];
    front.p    = {{MW{1'b0}}, 1'b1, X[M-1:0], 1'b1}
               * {{MW{1'b0}}, 1'b1, Y[M-1:0], 1'b1};
    front.es   = {2'b00, X[W-2:M]} + {2'b00, Y[W-2:M]} - BIAS;
    front.tag  = in_tag;
  end

  if (STAGES == 1) begin : g_single
    assign back       = front;
    assign back_valid = in_valid;
  end else begin : g_pipe
    localparam int unsigned ND = STAGES - 1;
    mid_t       mid_q [ND];
    logic [ND-1:0] mid_v;

    // Stage 1 captures decoded operands; further stages are pure delay
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        mid_v <= '0;
        for (int unsigned i = 0; i < ND; i++) mid_q[i] <= '0;
      end else if (!stall) begin
        mid_v[0] <= in_valid;
        mid_q[0] <= front;
        for (int unsigned i = 1; i < ND; i++) begin
          mid_v[i] <= mid_v[i-1];
          mid_q[i] <= mid_q[i-1];
        end
      end
    end

    assign back       = mid_q[ND-1];
    assign back_valid = mid_v[ND-1];
  end

  // Low product bits fall below the truncation point
  assign p_unused = ^back.p[MW-1:0];

  // Normalise, range-check and pack the result feeding the output register
  always_comb begin
    es_n   = $signed(back.es);
    mant_n = back.p[PW-3:MW];
    if (back.p[PW-1]) begin
      es_n   = es_n + ES_ONE;
      mant_n = back.p[PW-2:MW+1];
    end

    z_d     = '0;
    flags_d = '0;
    case (back.cls)
      CLS_NAN: begin
        z_d     = {1'b0, {E{1'b1}}, {M{1'b1}}};
        flags_d = 4'b1001;
      end
      CLS_INF: begin
        z_d     = {back.sign, {E{1'b1}}, {M{1'b0}}};
        flags_d = 4'b0001;
      end
      CLS_ZERO: begin
        z_d     = {back.sign, {(E + M){1'b0}}};
        flags_d = 4'b0001;
      end
      default: begin
        if (es_n >= ES_MAX) begin
          z_d     = {back.sign, {E{1'b1}}, {M{1'b0}}};
          flags_d = 4'b0100;
        end else if (es_n <= ES_ZERO) begin
          z_d     = {back.sign, {(E + M){1'b0}}};
          flags_d = 4'b0010;
        end else begin
          z_d = {back.sign, es_n[E-1:0], mant_n};
        end
      end
    endcase
  end

  // Output register; holds its contents while the consumer stalls
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid <= 1'b0;
      Z         <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (!stall) begin
      out_valid <= back_valid;
      Z         <= z_d;
      out_tag   <= back.tag;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fphub_mult_pipe.sv
// Directed bench for fphub_mult_pipe: four instances with STAGES = 1..4,
// hand-computed vectors, a backpressure stream, mid-stream reset and a
// randomised sweep checked against a small reference model.
module tb_fphub_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        iv   [4];
  logic        ordy [4];
  logic [31:0] xx   [4];
  logic [31:0] yy   [4];
  logic [3:0]  it   [4];
  wire         irdy [4];
  wire         ov   [4];
  wire  [31:0] zz   [4];
  wire  [3:0]  ot   [4];
  wire  [3:0]  fl   [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fphub_mult_pipe #(.M(23), .E(8), .STAGES(g + 1), .TAG_W(4)) dut (
      .clk      (clk),
      .rst_l    (rst_l),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .X        (xx[g]),
      .Y        (yy[g]),
      .in_tag   (it[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .Z        (zz[g]),
      .out_tag  (ot[g]),
      .flags    (fl[g])
    );
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Returns {flags, Z} for M=23, E=8
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic xz, xi, xn, yz, yi, yn, s;
    logic [63:0] a, b, p;
    logic [22:0] mant;
    int es;
    xz = (x[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yz = (y[30:23] == 8'h00);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    s  = x[31] ^ y[31];
    if (xn || yn || (xz && yi) || (xi && yz)) return {4'b1001, 32'h7FFFFFFF};
    if (xi || yi) return {4'b0001, s, 8'hFF, 23'h0};
    if (xz || yz) return {4'b0001, s, 31'h0};
    a  = {39'h0, 1'b1, x[22:0], 1'b1};
    b  = {39'h0, 1'b1, y[22:0], 1'b1};
    p  = a * b;
    es = int'(x[30:23]) + int'(y[30:23]) - 128;
    if (p[49]) begin
      mant = p[48:26];
      es   = es + 1;
    end else begin
      mant = p[47:25];
    end
    if (es >= 255) return {4'b0100, s, 8'hFF, 23'h0};
    if (es <= 0)   return {4'b0010, s, 31'h0};
    return {4'b0000, s, 8'(es), mant};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      2: r[30:23] = 8'hFF;
      3, 4: ;
      default: r[30:23] = 8'(96 + $urandom_range(0, 63));
    endcase
    return r;
  endfunction

  // One isolated pair: exact latency, result, tag and flags
  task automatic single(input int d, input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] tg, input logic [31:0] ez, input logic [3:0] ef);
    int st;
    st = d + 1;
    ordy[d] = 1'b1;
    iv[d] = 1'b1; xx[d] = x; yy[d] = y; it[d] = tg;
    for (int k = 1; k <= st; k++) begin
      @(negedge clk);
      if (k == 1) iv[d] = 1'b0;
      if (k == st - 1) check({nm, "_early"}, 64'(ov[d]), 64'(0));
    end
    check({nm, "_valid"}, 64'(ov[d]), 64'(1));
    check({nm, "_z"},     64'(zz[d]), 64'(ez));
    check({nm, "_tag"},   64'(ot[d]), 64'(tg));
    check({nm, "_flags"}, 64'(fl[d]), 64'(ef));
    @(negedge clk);
  endtask

  // Stream n pairs; mode 0 = directed 5-cycle stall, mode 1 = random
  task automatic stream(input int d, input int n, input int mode);
    logic [39:0] q[$];
    logic [35:0] r;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < n * 10 + 50) begin
      if (mode == 0) begin
        ordy[d] = !(cyc >= 4 && cyc < 9);
        iv[d]   = (sent < n) && (cyc != 2);
        xx[d]   = {1'b0, 8'(124 + sent), 23'(sent * 37)};
        yy[d]   = {1'(sent & 1), 8'h81, 23'(sent * 1001)};
      end else begin
        ordy[d] = ($urandom_range(0, 3) != 0);
        iv[d]   = (sent < n) && ($urandom_range(0, 4) != 0);
        xx[d]   = rand_op();
        yy[d]   = rand_op();
      end
      it[d] = 4'(sent);
      #1;
      if (mode == 0 && cyc >= 4 && cyc < 9)
        check($sformatf("s%0d_stall_in_ready", d + 1), 64'(irdy[d]), 64'(0));
      if (ov[d]) begin
        if (q.size() == 0) begin
          check($sformatf("s%0d_spurious", d + 1), 64'(ov[d]), 64'(0));
        end else begin
          check($sformatf("s%0d_z", d + 1),     64'(zz[d]), 64'(q[0][31:0]));
          check($sformatf("s%0d_flags", d + 1), 64'(fl[d]), 64'(q[0][35:32]));
          check($sformatf("s%0d_tag", d + 1),   64'(ot[d]), 64'(q[0][39:36]));
          if (ordy[d]) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (iv[d] && irdy[d]) begin
        r = ref_mul(xx[d], yy[d]);
        q.push_back({it[d], r});
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    check($sformatf("s%0d_count", d + 1), 64'(got), 64'(n));
    @(negedge clk);
    @(negedge clk);
    check($sformatf("s%0d_idle", d + 1), 64'(ov[d]), 64'(0));
  endtask

  // Reset with two pairs in flight on the STAGES=2 instance
  task automatic reset_midstream();
    int seen;
    logic [35:0] r;
    seen = 0;
    ordy[1] = 1'b1;
    iv[1] = 1'b1; xx[1] = 32'h40000000; yy[1] = 32'h40400000; it[1] = 4'hA;
    @(negedge clk);
    xx[1] = 32'h3F800000; yy[1] = 32'h3F800000; it[1] = 4'hB;
    @(negedge clk);
    iv[1] = 1'b0;
    r = ref_mul(32'h40000000, 32'h40400000);
    check("rst_pre_valid", 64'(ov[1]), 64'(1));
    check("rst_pre_z",     64'(zz[1]), 64'(r[31:0]));
    rst_l = 1'b0;
    #1;
    check("rst_valid",    64'(ov[1]),   64'(0));
    check("rst_z",        64'(zz[1]),   64'(0));
    check("rst_tag",      64'(ot[1]),   64'(0));
    check("rst_flags",    64'(fl[1]),   64'(0));
    check("rst_in_ready", 64'(irdy[1]), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov[1]) seen++;
    end
    check("rst_stale", 64'(seen), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; xx[d] = '0; yy[d] = '0; it[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_s%0d_valid", d + 1),    64'(ov[d]),   64'(0));
      check($sformatf("reset_s%0d_z", d + 1),        64'(zz[d]),   64'(0));
      check($sformatf("reset_s%0d_tag", d + 1),      64'(ot[d]),   64'(0));
      check($sformatf("reset_s%0d_flags", d + 1),    64'(fl[d]),   64'(0));
      check($sformatf("reset_s%0d_in_ready", d + 1), 64'(irdy[d]), 64'(1));
    end
    @(negedge clk);

    single(1, "basic",     32'h40000000, 32'h40000000, 4'h3, 32'h40000001, 4'b0000);
    single(1, "mant_ovf",  32'h40000000, 32'hC07FFFFF, 4'h5, 32'hC0800000, 4'b0000);
    check("mant_ovf_model", 64'(ref_mul(32'h40000000, 32'hC07FFFFF)), 64'({4'b0000, 32'hC0800000}));
    single(1, "overflow",  32'h60000000, 32'h60000000, 4'h6, 32'h7F800000, 4'b0100);
    single(1, "es_255",    32'h5F800000, 32'h60000000, 4'h7, 32'h7F800000, 4'b0100);
    single(1, "es_254",    32'h5F800000, 32'h5F800000, 4'h8, 32'h7F000001, 4'b0000);
    single(1, "underflow", 32'h20000000, 32'h20000000, 4'h9, 32'h00000000, 4'b0010);
    single(1, "es_1",      32'h20800000, 32'h20000000, 4'hA, 32'h00800001, 4'b0000);
    single(1, "zero_inf",  32'h00000000, 32'h7F800000, 4'hB, 32'h7FFFFFFF, 4'b1001);
    single(1, "nan",       32'h7FC00000, 32'h3F800000, 4'hC, 32'h7FFFFFFF, 4'b1001);
    single(1, "neg_zero",  32'h80000000, 32'h40000000, 4'hD, 32'h80000000, 4'b0001);
    single(1, "dirty_zero",32'h00123456, 32'h40000000, 4'hE, 32'h00000000, 4'b0001);
    single(1, "neg_inf",   32'hFF800000, 32'h40000000, 4'hF, 32'hFF800000, 4'b0001);
    single(1, "inf_big",   32'h7F800000, 32'h7F000000, 4'h1, 32'h7F800000, 4'b0001);
    single(0, "lat_s1",    32'h40000000, 32'h40000000, 4'h2, 32'h40000001, 4'b0000);
    single(3, "lat_s4",    32'h40000000, 32'h40000000, 4'h4, 32'h40000001, 4'b0000);

    stream(2, 10, 0);
    reset_midstream();
    stream(0, 40, 1);
    stream(3, 40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
